// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the 32-bit to 16-bit SRAM sequencer.
package arm_mem_pkg;

    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StLo,
        StHi,
        StDone
    } state_e;

    // SRAM word offset of a byte address; the subtraction wraps mod 2^32, no range check.
    function automatic logic [SRAM_AW-2:0] word_off(input logic [31:0] byte_addr,
                                                    input logic [31:0] base);
        logic [31:0] diff;
        diff = byte_addr - base;
        return diff[SRAM_AW:2];
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter: clears on clr, counts on en, flags the last of WAIT_CYCLES clocks.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/sram_mem_ctrl.sv
// Splits 32-bit MEM-stage loads/stores into low/high half-word SRAM accesses, freezing via ready.
// Optional: define SRAM_POSTED_WRITE_EN to let writes complete without freezing the pipeline.
module sram_mem_ctrl
    import arm_mem_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    localparam logic [31:0] BASE = 32'(BASE_ADDR);

    state_e             state;
    logic               is_write;
    logic [SRAM_DW-1:0] wdata_hi;
    logic               req;
    logic               take_write;
    logic               tc;
    logic               cnt_en;
    logic               cnt_clr;

    assign req        = mem_read | mem_write;
    // A simultaneous read and write performs only the read.
    assign take_write = mem_write & ~mem_read;
    assign cnt_en     = (state == StLo) || (state == StHi);
    assign cnt_clr    = !cnt_en || tc;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk(clk),
        .rst(rst),
        .clr(cnt_clr),
        .en (cnt_en),
        .tc (tc)
    );

    always_comb begin
        ready = 1'b0;
        case (state)
            StIdle:  ready = ~(mem_read | (mem_write & ~POSTED));
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            is_write    <= 1'b0;
            wdata_hi    <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            case (state)
                StIdle: begin
                    if (req) begin
                        state       <= StLo;
                        is_write    <= take_write;
                        wdata_hi    <= wdata[31:16];
                        sram_addr   <= {word_off(addr, BASE), HALF_LO};
                        sram_ce_n   <= 1'b0;
                        sram_ub_n   <= 1'b0;
                        sram_lb_n   <= 1'b0;
                        sram_oe_n   <= take_write;
                        sram_we_n   <= ~take_write;
                        sram_dq_oe  <= take_write;
                        sram_dq_out <= take_write ? wdata[15:0] : '0;
                    end
                end
                StLo: begin
                    if (tc) begin
                        state        <= StHi;
                        sram_addr[0] <= HALF_HI;
                        if (is_write) begin
                            sram_dq_out <= wdata_hi;
                        end else begin
                            rdata[15:0] <= sram_dq_in;
                        end
                    end
                end
                StHi: begin
                    if (tc) begin
                        state       <= (is_write && POSTED) ? StIdle : StDone;
                        sram_ce_n   <= 1'b1;
                        sram_ub_n   <= 1'b1;
                        sram_lb_n   <= 1'b1;
                        sram_oe_n   <= 1'b1;
                        sram_we_n   <= 1'b1;
                        sram_dq_oe  <= 1'b0;
                        sram_dq_out <= '0;
                        if (!is_write) begin
                            rdata[31:16] <= sram_dq_in;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
